// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// unlit pattern and a polarity helper.
package seg_pkg;

  // Bit order is g,f,e,d,c,b,a; a 0 lights the segment (active-low form).
  localparam logic [6:0] SEG_UNLIT_LOW = 7'b1111111;

  localparam logic [6:0] HEX_GLYPH_LOW [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] glyph_low,
                                              input bit         active_low);
    return active_low ? glyph_low : ~glyph_low;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder with output polarity applied.
module seg_hex_decode
  import seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = seg_polarity(HEX_GLYPH_LOW[i_nibble], SEG_ACTIVE_LOW);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous value
// update, optional leading-zero blanking and fully registered display pins.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    ENABLE,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    FRAME_DONE
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = seg_polarity(SEG_UNLIT_LOW, SEG_ACTIVE_LOW);
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_active_val;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_frame_end;
  logic [3:0]              w_nibble;
  logic                    w_dp_bit;
  logic [NUM_DIGITS-1:0]   w_an_onehot;
  logic                    w_upper_nonzero;
  logic                    w_blank;
  logic [6:0]              w_glyph;

  assign w_tick      = (r_presc == PRE_LAST);
  assign w_frame_end = w_tick && (r_idx == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_frame_done <= w_frame_end;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // The active copy only changes on a frame boundary, so one frame is never
  // a mix of old and new digits; a load on the boundary itself bypasses the shadow.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (LOAD) begin
        r_shadow_val <= VALUE;
        r_shadow_dp  <= DP_IN;
      end
      if (w_frame_end && LOAD) begin
        r_active_val <= VALUE;
        r_active_dp  <= DP_IN;
        r_pending    <= 1'b0;
      end else if (w_frame_end && r_pending) begin
        r_active_val <= r_shadow_val;
        r_active_dp  <= r_shadow_dp;
        r_pending    <= 1'b0;
      end else if (LOAD) begin
        r_pending    <= 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_nibble        = 4'h0;
    w_dp_bit        = 1'b0;
    w_an_onehot     = '0;
    w_upper_nonzero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble       = r_active_val[4*i +: 4];
        w_dp_bit       = r_active_dp[i];
        w_an_onehot[i] = 1'b1;
      end
      if ((IDX_W'(i) >= r_idx) && (r_active_val[4*i +: 4] != 4'h0)) begin
        w_upper_nonzero = 1'b1;
      end
    end
    w_blank = BLANK_LEADING && (r_idx != '0) && !w_upper_nonzero;
  end

  seg_hex_decode #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Pins load on the tick edge so AN and SEG switch together; ENABLE low
  // darkens the pins on the very next edge regardless of the slot position.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
    end else if (!ENABLE) begin
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
      r_an  <= AN_OFF;
    end else if (w_tick) begin
      r_seg <= w_blank ? SEG_OFF : w_glyph;
      r_dp  <= w_dp_bit ? ~DP_OFF : DP_OFF;
      r_an  <= AN_ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;
    end
  end

  assign SEG        = r_seg;
  assign DP         = r_dp;
  assign AN         = r_an;
  assign FRAME_DONE = r_frame_done;

endmodule
